// File: rtl/armleocpu_plic_target_scheduler.sv
// Per-target PLIC scheduler: walks the sources one per cycle to find the best eligible
// interrupt, drives the hart's external interrupt line and tracks claim/complete state.
module armleocpu_plic_target_scheduler #(
  parameter int SOURCE_COUNT   = 31,
  parameter int PRIORITY_WIDTH = 3,
  parameter int ID_WIDTH       = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [SOURCE_COUNT-1:0]            pending,
  input  logic [SOURCE_COUNT-1:0]            enable,
  input  logic [SOURCE_COUNT*PRIORITY_WIDTH-1:0] priorities,
  input  logic [PRIORITY_WIDTH-1:0]          threshold,
  input  logic                               claim_req,
  output logic                               claim_ack,
  output logic [ID_WIDTH-1:0]                claim_id,
  input  logic                               complete_req,
  input  logic [ID_WIDTH-1:0]                complete_id,
  output logic                               eip,
  output logic [SOURCE_COUNT-1:0]            in_service
);

  logic [ID_WIDTH-1:0]       idx_q, idx_d;
  logic [ID_WIDTH-1:0]       run_id_q, run_id_d;
  logic [PRIORITY_WIDTH-1:0] run_max_q, run_max_d;
  logic [ID_WIDTH-1:0]       best_id_q, best_id_d;
  logic [PRIORITY_WIDTH-1:0] best_prio_q, best_prio_d;
  logic                      eip_q, eip_d;
  logic                      claim_ack_q, claim_ack_d;
  logic [ID_WIDTH-1:0]       claim_id_q, claim_id_d;
  logic [SOURCE_COUNT-1:0]   in_service_q, in_service_d;

  logic [SOURCE_COUNT-1:0]   elig;
  logic                      cur_elig;
  logic [PRIORITY_WIDTH-1:0] cur_prio;
  logic                      best_elig;
  logic                      step_take;
  logic [PRIORITY_WIDTH-1:0] step_max;
  logic [ID_WIDTH-1:0]       step_id;
  logic                      scan_end;
  logic                      claim_hit;

  assign elig = pending & enable & ~in_service_q;

  // Select the source under the scan pointer and re-check the latched winner.
  always_comb begin
    cur_elig  = 1'b0;
    cur_prio  = '0;
    best_elig = 1'b0;
    for (int i = 0; i < SOURCE_COUNT; i++) begin
      if (idx_q == ID_WIDTH'(i + 1)) begin
        cur_elig = elig[i];
        cur_prio = priorities[i*PRIORITY_WIDTH +: PRIORITY_WIDTH];
      end
      if (best_id_q == ID_WIDTH'(i + 1)) begin
        best_elig = elig[i];
      end
    end
  end

  // Strict compare keeps the lower ID on ties and never lets priority 0 win.
  assign step_take = cur_elig && (cur_prio > run_max_q);
  assign step_max  = step_take ? cur_prio : run_max_q;
  assign step_id   = step_take ? idx_q : run_id_q;
  assign scan_end  = (idx_q == ID_WIDTH'(SOURCE_COUNT));
  assign claim_hit = (best_id_q != '0) && best_elig && (best_prio_q > threshold);

  always_comb begin
    idx_d       = idx_q + ID_WIDTH'(1);
    run_max_d   = step_max;
    run_id_d    = step_id;
    best_id_d   = best_id_q;
    best_prio_d = best_prio_q;
    eip_d       = eip_q;
    claim_ack_d = 1'b0;
    claim_id_d  = '0;
    if (claim_req) begin
      idx_d       = ID_WIDTH'(1);
      run_max_d   = '0;
      run_id_d    = '0;
      best_id_d   = '0;
      best_prio_d = '0;
      eip_d       = 1'b0;
      claim_ack_d = 1'b1;
      claim_id_d  = claim_hit ? best_id_q : '0;
    end else if (scan_end) begin
      best_id_d   = step_id;
      best_prio_d = step_max;
      eip_d       = (step_max > threshold);
      idx_d       = ID_WIDTH'(1);
      run_max_d   = '0;
      run_id_d    = '0;
    end
  end

  // Complete is applied first so a same-ID claim in the same cycle leaves the bit set.
  always_comb begin
    in_service_d = in_service_q;
    for (int i = 0; i < SOURCE_COUNT; i++) begin
      if (complete_req && (complete_id == ID_WIDTH'(i + 1))) begin
        in_service_d[i] = 1'b0;
      end
      if (claim_req && claim_hit && (best_id_q == ID_WIDTH'(i + 1))) begin
        in_service_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= ID_WIDTH'(1);
      run_max_q    <= '0;
      run_id_q     <= '0;
      best_id_q    <= '0;
      best_prio_q  <= '0;
      eip_q        <= 1'b0;
      claim_ack_q  <= 1'b0;
      claim_id_q   <= '0;
      in_service_q <= '0;
    end else begin
      idx_q        <= idx_d;
      run_max_q    <= run_max_d;
      run_id_q     <= run_id_d;
      best_id_q    <= best_id_d;
      best_prio_q  <= best_prio_d;
      eip_q        <= eip_d;
      claim_ack_q  <= claim_ack_d;
      claim_id_q   <= claim_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign eip        = eip_q;
  assign claim_ack  = claim_ack_q;
  assign claim_id   = claim_id_q;
  assign in_service = in_service_q;

endmodule

// File: doc/armleocpu_plic_target_scheduler.md
Name: armleocpu_plic_target_scheduler

Overview:
- Per-target sequential priority scheduler for the PLIC.
- Scans the interrupt sources one per clock cycle. Each step applies the matrix-cell rule: take the source if it is enabled and its priority is strictly greater than the running maximum.
- Latches the winning ID and priority, drives the target's external interrupt line, and runs the claim/complete handshake with in-service tracking.
- Sits between the gateway/priority registers and the target's claim/complete register interface.

Parameters:
- SOURCE_COUNT, 31, number of sources; IDs 1..SOURCE_COUNT; ID 0 means "no interrupt".
- PRIORITY_WIDTH, 3, width of each priority and of the threshold.
- ID_WIDTH, 5, width of IDs; must satisfy 2^ID_WIDTH > SOURCE_COUNT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pending  in  SOURCE_COUNT  gateway pending bits; bit i is source i+1.
- enable  in  SOURCE_COUNT  target enable bits; bit i is source i+1.
- priorities  in  SOURCE_COUNT*PRIORITY_WIDTH  flattened; slice i is source i+1.
- threshold  in  PRIORITY_WIDTH  target threshold.
- claim_req  in  1  single-cycle claim strobe.
- claim_ack  out  1  single-cycle, one cycle after claim_req.
- claim_id  out  ID_WIDTH  claimed ID; valid only while claim_ack=1, otherwise 0.
- complete_req  in  1  single-cycle complete strobe.
- complete_id  in  ID_WIDTH  ID being completed.
- eip  out  1  external interrupt pending to the hart.
- in_service  out  SOURCE_COUNT  claimed-but-not-completed bits; bit i is source i+1.

Behaviour:
- Reset (async, rst_n=0):
  - scan index = 1, running max = 0, running id = 0.
  - Result register: best_id = 0, best_prio = 0.
  - eip = 0, claim_ack = 0, claim_id = 0, in_service = 0.
- Eligibility of source s: pending & enable & !in_service, all for s.
- Scan step, one per cycle at index s:
  - If s is eligible and prio(s) > running max: running max = prio(s), running id = s.
  - Otherwise running max and running id hold.
  - Strict compare, so on equal priority the lower ID wins.
  - Priority-0 sources never win.
- Scan end, step at index SOURCE_COUNT:
  - Result register takes the final running max/id, including that last step's comparison.
  - eip <= (final max > threshold), strict compare.
  - index returns to 1 and running max/id return to 0.
  - Scanning is free-running.
  - Latency: an eligibility change is reflected on eip within 2*SOURCE_COUNT cycles.
- Claim (claim_req=1 at edge N). At edge N+1:
  - claim_ack = 1.
  - claim_id = best_id if best_id != 0, best_id is still eligible (checked at edge N), and best_prio > threshold; otherwise claim_id = 0.
  - On a nonzero claim, in_service[claim_id] is set at edge N+1.
  - Any claim_req aborts the current scan: index = 1, running max/id = 0, result cleared, eip = 0 until the next scan completes.
  - claim_ack and claim_id drop to 0 at N+2.
- claim_req while claim_ack=1 is legal and is handled as a new claim.
- The gateway clears pending using claim_ack & claim_id.
- Complete:
  - complete_req with 1 <= complete_id <= SOURCE_COUNT and in_service set: clear in_service at the next edge.
  - Out of range, ID 0, or not in service: silently ignored.
- Same-cycle claim and complete:
  - Both are processed.
  - Claim eligibility uses in_service before the complete.
  - If the complete and claim IDs coincide, the claim set wins.
- Threshold and priority changes mid-scan are allowed. The result reflects the values sampled at each step.
- Reset asserted mid-scan or mid-claim: all state returns to reset values immediately; no claim_ack is generated.

Test Plan (SOURCE_COUNT=4, PRIORITY_WIDTH=3, ID_WIDTH=3 unless noted):
- Reset, all inputs 0 -> eip=0, claim_ack=0, claim_id=0, in_service=0 after every edge for 20 cycles.
- pending=4'b0110, enable=4'b1111, prio{1..4}={1,5,5,2}, threshold=3 -> eip=1 within 8 cycles. A claim then gives claim_ack=1 and claim_id=2 (tie, lower ID wins), in_service=4'b0010, and eip=0 for at least 4 cycles.
- Same setup with source 2 in service and pending bit 1 cleared -> the next full scan selects ID 3 and eip=1.
- pending=4'b1000, prio4=3, threshold=3 -> eip stays 0. A claim gives claim_id=0, in_service unchanged.
- complete_id=2 while in service -> in_service bit 1 clears. complete_id=0, complete_id=7, and a repeat complete_id=2 -> no change.
- Same-cycle claim and complete of ID 2 (claim eligible) -> in_service[ID2] ends set. rst_n pulsed low mid-scan -> eip and in_service are 0 immediately, before the next clock edge.
